// File: rtl/fifo_tx_buffer.sv
// rtl/fifo_tx_buffer.sv - APB-written TX byte FIFO with LSB-first serializer (optional flush: FIFO_TX_FLUSH_EN)
module fifo_tx_buffer #(
   parameter int DEPTH   = 256,
   parameter int DATA_W  = 8,
   parameter int BIT_DIV = 2
) (
   input  logic              clk,
   input  logic              reset_n,
   input  logic [7:0]        paddr,
   input  logic [DATA_W-1:0] pwdata,
   input  logic              psel,
   input  logic              penable,
   input  logic              pwrite,
   output logic              pready,
   output logic              pslverr,
   input  logic              en_IQ,
   output logic              data_out,
   output logic              IQ_rate,
   output logic              mem_state
);

   localparam int AW    = $clog2(DEPTH);
   localparam int CW    = AW + 1;
   localparam int DIV_W = (BIT_DIV > 1) ? $clog2(BIT_DIV) : 1;
   localparam int BIT_W = $clog2(DATA_W);

   typedef enum logic {IDLE, SHIFT} state_t;

   state_t            state, state_nxt;
   logic [DATA_W-1:0] mem [DEPTH];
   logic [AW-1:0]     wr_ptr, rd_ptr;
   logic [CW-1:0]     count;
   logic [DATA_W-1:0] shreg;
   logic [DIV_W-1:0]  div_cnt;
   logic [BIT_W-1:0]  bit_cnt;

   logic access, full, push, flush, can_pop, pop, bit_end, byte_end;

   assign access = psel & penable;
   assign full   = (count == CW'(DEPTH));
   assign push   = access & pwrite & (paddr == 8'h00) & ~full;
`ifdef FIFO_TX_FLUSH_EN
   assign flush  = access & pwrite & (paddr == 8'h04);
`else
   assign flush  = 1'b0;
`endif

   // Zero-wait-state APB: every accepted access is either a push or a flush, anything else errors
   assign pready    = access;
   assign pslverr   = access & ~push & ~flush;
   assign mem_state = full;

   assign can_pop  = en_IQ & (count != '0);
   assign bit_end  = (div_cnt == DIV_W'(BIT_DIV - 1));
   assign byte_end = bit_end & (bit_cnt == BIT_W'(DATA_W - 1));
   // Pop on leaving IDLE, or at the very end of a byte to keep the stream gapless; flush wins
   assign pop      = ~flush & can_pop & ((state == IDLE) | ((state == SHIFT) & byte_end));

   // Serializer state register
   always_ff @(posedge clk) begin
      if (!reset_n) state <= IDLE;
      else          state <= state_nxt;
   end

   // Serializer next-state logic
   always_comb begin
      state_nxt = state;
      if (flush) begin
         state_nxt = IDLE;
      end else begin
         case (state)
            IDLE:    if (can_pop) state_nxt = SHIFT;
            SHIFT:   if (byte_end && !can_pop) state_nxt = IDLE;
            default: state_nxt = IDLE;
         endcase
      end
   end

   // Serializer outputs: strobe marks the first cycle of every bit
   always_comb begin
      data_out = 1'b0;
      IQ_rate  = 1'b0;
      if (state == SHIFT) begin
         data_out = shreg[0];
         IQ_rate  = (div_cnt == '0);
      end
   end

   // FIFO storage; contents need no reset since count gates every read
   always_ff @(posedge clk) begin
      if (push) mem[wr_ptr] <= pwdata;
   end

   // Pointers, occupancy and shift datapath
   always_ff @(posedge clk) begin
      if (!reset_n || flush) begin
         wr_ptr  <= '0;
         rd_ptr  <= '0;
         count   <= '0;
         shreg   <= '0;
         div_cnt <= '0;
         bit_cnt <= '0;
      end else begin
         if (push) wr_ptr <= wr_ptr + 1'b1;
         if (pop)  rd_ptr <= rd_ptr + 1'b1;
         case ({push, pop})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
         if (pop) begin
            shreg   <= mem[rd_ptr];
            div_cnt <= '0;
            bit_cnt <= '0;
         end else if (state == SHIFT) begin
            if (bit_end) begin
               div_cnt <= '0;
               bit_cnt <= byte_end ? '0 : bit_cnt + 1'b1;
               shreg   <= shreg >> 1;
            end else begin
               div_cnt <= div_cnt + 1'b1;
            end
         end
      end
   end

endmodule

// File: tb/tb_fifo_tx_buffer.sv
// tb/tb_fifo_tx_buffer.sv - directed self-checking bench for fifo_tx_buffer
module tb_fifo_tx_buffer;

   logic       clk = 1'b0;
   logic       reset_n;
   logic [7:0] paddr;
   logic [7:0] pwdata;
   logic       psel, penable, pwrite, en_IQ;
   logic       pready, pslverr, data_out, IQ_rate, mem_state;

   int checks   = 0;
   int failures = 0;

   fifo_tx_buffer #(.DEPTH(256), .DATA_W(8), .BIT_DIV(2)) dut (
      .clk(clk), .reset_n(reset_n), .paddr(paddr), .pwdata(pwdata),
      .psel(psel), .penable(penable), .pwrite(pwrite),
      .pready(pready), .pslverr(pslverr), .en_IQ(en_IQ),
      .data_out(data_out), .IQ_rate(IQ_rate), .mem_state(mem_state)
   );

   always #5 clk = ~clk;

   // Each byte bit held for two cycles, LSB first
   function automatic logic [15:0] exp_bits(input logic [7:0] b);
      logic [15:0] r;
      for (int k = 0; k < 16; k++) r[k] = b[k/2];
      return r;
   endfunction

   // Samples one byte period (16 cycles) at negedges; optionally drops en_IQ after stop_after samples
   task automatic collect_byte(input int stop_after, output logic [15:0] dv,
                               output logic [15:0] rv, output logic ms0);
      for (int j = 0; j < 16; j++) begin
         @(negedge clk);
         dv[j] = data_out;
         rv[j] = IQ_rate;
         if (j == 0) ms0 = mem_state;
         if (j == stop_after - 1) en_IQ = 1'b0;
      end
   endtask

   task automatic apb_write(input logic [7:0] a, input logic [7:0] d);
      @(negedge clk);
      psel = 1'b1; penable = 1'b1; pwrite = 1'b1; paddr = a; pwdata = d;
      @(negedge clk);
      psel = 1'b0; penable = 1'b0; pwrite = 1'b0;
   endtask

   task automatic test_reset;
      reset_n = 1'b0; psel = 0; penable = 0; pwrite = 0; paddr = 0; pwdata = 0; en_IQ = 0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      checks++; if (data_out !== 1'b0) begin failures++; $display("FAIL reset_data_out got=%b exp=0", data_out); end
      checks++; if (IQ_rate !== 1'b0) begin failures++; $display("FAIL reset_iq_rate got=%b exp=0", IQ_rate); end
      checks++; if (mem_state !== 1'b0) begin failures++; $display("FAIL reset_mem_state got=%b exp=0", mem_state); end
      checks++; if (pslverr !== 1'b0) begin failures++; $display("FAIL reset_pslverr got=%b exp=0", pslverr); end
      checks++; if (pready !== 1'b0) begin failures++; $display("FAIL reset_pready got=%b exp=0", pready); end
      reset_n = 1'b1;
   endtask

   task automatic test_fill;
      for (int i = 0; i < 256; i++) begin
         @(negedge clk);
         checks++; if (mem_state !== 1'b0) begin failures++; $display("FAIL fill_not_full i=%0d got=%b exp=0", i, mem_state); end
         psel = 1'b1; penable = 1'b1; pwrite = 1'b1; paddr = 8'h00; pwdata = 8'(i + 1);
         #1;
         checks++; if (pready !== 1'b1) begin failures++; $display("FAIL fill_pready i=%0d got=%b exp=1", i, pready); end
         checks++; if (pslverr !== 1'b0) begin failures++; $display("FAIL fill_pslverr i=%0d got=%b exp=0", i, pslverr); end
      end
      @(negedge clk);
      psel = 1'b0; penable = 1'b0; pwrite = 1'b0;
      checks++; if (mem_state !== 1'b1) begin failures++; $display("FAIL fill_full got=%b exp=1", mem_state); end
   endtask

   task automatic test_overflow;
      @(negedge clk);
      psel = 1'b1; penable = 1'b1; pwrite = 1'b1; paddr = 8'h00; pwdata = 8'hAA;
      #1;
      checks++; if (pslverr !== 1'b1) begin failures++; $display("FAIL overflow_pslverr got=%b exp=1", pslverr); end
      @(negedge clk);
      psel = 1'b0; penable = 1'b0; pwrite = 1'b0;
      checks++; if (mem_state !== 1'b1) begin failures++; $display("FAIL overflow_full got=%b exp=1", mem_state); end
   endtask

   task automatic test_readout;
      logic [15:0] dv, rv;
      logic        ms0;
      @(negedge clk);
      en_IQ = 1'b1;
      for (int i = 0; i < 256; i++) begin
         collect_byte(99, dv, rv, ms0);
         checks++; if (dv !== exp_bits(8'(i + 1))) begin failures++; $display("FAIL readout_bits byte=%0d got=%h exp=%h", i, dv, exp_bits(8'(i + 1))); end
         checks++; if (rv !== 16'h5555) begin failures++; $display("FAIL readout_strobe byte=%0d got=%h exp=5555", i, rv); end
         if (i == 0) begin
            checks++; if (ms0 !== 1'b0) begin failures++; $display("FAIL readout_full_drop got=%b exp=0", ms0); end
         end
      end
      for (int j = 0; j < 4; j++) begin
         @(negedge clk);
         checks++; if ({data_out, IQ_rate} !== 2'b00) begin failures++; $display("FAIL readout_idle cyc=%0d got=%b exp=00", j, {data_out, IQ_rate}); end
      end
      en_IQ = 1'b0;
   endtask

   task automatic test_error_decode;
      @(negedge clk);
      psel = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = 8'h10;
      #1;
      checks++; if ({pready, pslverr} !== 2'b00) begin failures++; $display("FAIL setup_phase got=%b exp=00", {pready, pslverr}); end
      @(negedge clk);
      psel = 1'b1; penable = 1'b1; pwrite = 1'b0; paddr = 8'h00;
      #1;
      checks++; if ({pready, pslverr} !== 2'b11) begin failures++; $display("FAIL read_err got=%b exp=11", {pready, pslverr}); end
      @(negedge clk);
      pwrite = 1'b1; paddr = 8'h10; pwdata = 8'h77;
      #1;
      checks++; if (pslverr !== 1'b1) begin failures++; $display("FAIL bad_addr_err got=%b exp=1", pslverr); end
      @(negedge clk);
      paddr = 8'h04;
      #1;
`ifdef FIFO_TX_FLUSH_EN
      checks++; if (pslverr !== 1'b0) begin failures++; $display("FAIL flush_err got=%b exp=0", pslverr); end
`else
      checks++; if (pslverr !== 1'b1) begin failures++; $display("FAIL flush_unmapped_err got=%b exp=1", pslverr); end
`endif
      @(negedge clk);
      psel = 1'b0; penable = 1'b0; pwrite = 1'b0;
      en_IQ = 1'b1;
      // FIFO must still be empty: nothing may stream
      for (int j = 0; j < 6; j++) begin
         @(negedge clk);
         checks++; if ({data_out, IQ_rate} !== 2'b00) begin failures++; $display("FAIL err_no_data cyc=%0d got=%b exp=00", j, {data_out, IQ_rate}); end
      end
      en_IQ = 1'b0;
   endtask

   task automatic test_underrun_stop;
      logic [15:0] dv, rv;
      logic        ms0;
      apb_write(8'h00, 8'h5A);
      apb_write(8'h00, 8'h33);
      en_IQ = 1'b1;
      collect_byte(6, dv, rv, ms0);
      checks++; if (dv !== exp_bits(8'h5A)) begin failures++; $display("FAIL stop_bits got=%h exp=%h", dv, exp_bits(8'h5A)); end
      checks++; if (rv !== 16'h5555) begin failures++; $display("FAIL stop_strobe got=%h exp=5555", rv); end
      for (int j = 0; j < 6; j++) begin
         @(negedge clk);
         checks++; if ({data_out, IQ_rate} !== 2'b00) begin failures++; $display("FAIL stop_idle cyc=%0d got=%b exp=00", j, {data_out, IQ_rate}); end
      end
      apb_write(8'h00, 8'hC4);
      en_IQ = 1'b1;
      collect_byte(99, dv, rv, ms0);
      checks++; if (dv !== exp_bits(8'h33)) begin failures++; $display("FAIL resume_first got=%h exp=%h", dv, exp_bits(8'h33)); end
      collect_byte(99, dv, rv, ms0);
      checks++; if (dv !== exp_bits(8'hC4)) begin failures++; $display("FAIL resume_second got=%h exp=%h", dv, exp_bits(8'hC4)); end
      checks++; if (rv !== 16'h5555) begin failures++; $display("FAIL resume_strobe got=%h exp=5555", rv); end
      @(negedge clk);
      checks++; if ({data_out, IQ_rate} !== 2'b00) begin failures++; $display("FAIL resume_idle got=%b exp=00", {data_out, IQ_rate}); end
      en_IQ = 1'b0;
   endtask

   task automatic test_reset_mid;
      apb_write(8'h00, 8'hFF);
      apb_write(8'h00, 8'hFF);
      en_IQ = 1'b1;
      repeat (5) @(negedge clk);
      checks++; if (data_out !== 1'b1) begin failures++; $display("FAIL mid_streaming got=%b exp=1", data_out); end
      reset_n = 1'b0;
      @(negedge clk);
      reset_n = 1'b1;
      checks++; if ({data_out, IQ_rate} !== 2'b00) begin failures++; $display("FAIL mid_reset_abort got=%b exp=00", {data_out, IQ_rate}); end
      for (int j = 0; j < 4; j++) begin
         @(negedge clk);
         checks++; if ({data_out, IQ_rate, mem_state} !== 3'b000) begin failures++; $display("FAIL mid_reset_empty cyc=%0d got=%b exp=000", j, {data_out, IQ_rate, mem_state}); end
      end
      en_IQ = 1'b0;
   endtask

   initial begin
      test_reset();
      test_fill();
      test_overflow();
      test_readout();
      test_error_decode();
      test_underrun_stop();
      test_reset_mid();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/fifo_tx_buffer.md
Name: fifo_tx_buffer

Overview:
- Transmit-side byte FIFO for the Zigbee baseband.
- The CPU pushes payload bytes through an APB slave write port.
- When the modem asserts en_IQ, the block pops bytes and serializes them LSB-first onto a 1-bit stream, with a bit-rate strobe, for the I/Q spreader/modulator.
- Single clock domain.

Parameters:
- DEPTH, 256, number of byte entries; power of two, at least 2.
- DATA_W, 8, FIFO word width and serializer length.
- BIT_DIV, 2, clk cycles per serialized bit; at least 1.

Ports:
- clk  in  1  system clock; APB and serializer both run on it.
- reset_n  in  1  reset, synchronous, active-low.
- paddr  in  8  APB address.
- pwdata  in  8  APB write data.
- psel  in  1  APB select.
- penable  in  1  APB access phase.
- pwrite  in  1  APB write (1) / read (0).
- pready  out  1  APB ready.
- pslverr  out  1  APB error.
- en_IQ  in  1  serializer enable from the modem.
- data_out  out  1  serial TX bit.
- IQ_rate  out  1  one-cycle strobe marking each new data_out bit.
- mem_state  out  1  FIFO full flag.

Behaviour:
- Clock and reset: one clock, clk. Reset reset_n is synchronous and active-low; it is sampled only on the rising edge of clk.
- Reset state: pointers = 0, count = 0, serializer idle, shift register = 0, bit counter and divider = 0. Outputs pready=0, pslverr=0, data_out=0, IQ_rate=0, mem_state=0.
- pready = psel & penable (combinational; zero wait states).
- Access: every clk cycle with psel & penable = 1 is one transfer. penable held high across consecutive cycles gives back-to-back transfers.
- Write to paddr 0x00 when count < DEPTH: pwdata stored at wr_ptr, wr_ptr++ (wraps modulo DEPTH), count++. pslverr = 0.
- Write to paddr 0x00 when count == DEPTH: data dropped, pointers unchanged, pslverr = 1 during that access.
- Any read, or any write to an address not defined here: no state change, pslverr = 1.
- pslverr is combinational with pready and is 0 outside access cycles.
- mem_state = (count == DEPTH), registered with count.
- Full check uses count from before the edge. A write while full is rejected even if a pop happens in the same cycle.
- Serializer states: IDLE, SHIFT.
- IDLE -> SHIFT when en_IQ = 1 and count > 0:
  - Pop the byte at rd_ptr into the shift register; rd_ptr++ (wraps), count--.
  - data_out = bit0 and IQ_rate = 1 on the next cycle.
- SHIFT: each bit is held for BIT_DIV cycles. IQ_rate pulses for 1 cycle only on the first cycle of each bit.
- After bit DATA_W-1 has been held BIT_DIV cycles:
  - If en_IQ = 1 and count > 0: pop the next byte and present its bit0 on the following cycle. No gap; continuous stream.
  - Otherwise: go to IDLE.
- en_IQ deasserted mid-byte: the current byte completes; no further pop.
- In IDLE: data_out = 0, IQ_rate = 0.
- Underrun (en_IQ = 1, FIFO empty): stay IDLE, data_out = 0. Resume automatically once a byte is written.
- Simultaneous push and pop: both take effect; count unchanged.
- Reset mid-operation: the FIFO contents are logically discarded (count = 0) and the serializer aborts to IDLE on the same edge.

Optional Feature:
- Macro: FIFO_TX_FLUSH_EN.
- Defined: a write to paddr 0x04 (any pwdata) clears wr_ptr, rd_ptr and count, and forces the serializer to IDLE with data_out = 0. pslverr = 0.
- Flush has priority over any pop in the same cycle.
- Undefined: paddr 0x04 is an unmapped address; a write returns pslverr = 1 with no effect.

Test Plan:
- Reset: hold reset_n = 0 for 2 clk -> data_out=0, IQ_rate=0, mem_state=0, pslverr=0, pready=0.
- Fill: psel=penable=pwrite=1, paddr=0x00, pwdata = 0x01..0x00 over 256 consecutive cycles -> pready=1 and pslverr=0 on every cycle; mem_state=1 after the 256th write.
- Overflow: one further write of 0xAA while full -> pslverr=1 for that cycle; mem_state stays 1; 0xAA never appears on data_out.
- Readout: en_IQ=1 with BIT_DIV=2 -> first byte 0x01 appears as bits 1,0,0,0,0,0,0,0, each held 2 cycles, IQ_rate pulsing every 2 cycles. mem_state drops to 0 on the first pop. The 256 bytes stream contiguously in write order, then data_out=0 and IQ_rate=0.
- Error decode: read at paddr 0x00, and write at paddr 0x10 -> pslverr=1, FIFO count unchanged.
- Underrun/stop: write 0x5A, assert en_IQ, deassert en_IQ after 3 bits -> all 8 bits of 0x5A complete, then IDLE. A later write plus en_IQ resumes correctly.
